// File: rtl/shift_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// shift_defs
// Shared definitions for the shift execute stage: funct codes of the six
// shift instructions, the shiftop encoding seen by the shifter, and the
// decode helper that turns funct/shamt/rs into {shiftop, amount, illegal}.
// -----------------------------------------------------------------------------
package shift_defs;

  // Shift operation presented to the shifter.
  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,  // logical right
    OP_SRA  = 2'b01,  // arithmetic right (sign fill)
    OP_SLL  = 2'b10,  // left, zero fill
    OP_PASS = 2'b11   // rt passes through unchanged
  } shift_op_e;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef struct packed {
    shift_op_e  op;
    logic [4:0] amt;
    logic       illegal;
  } decode_t;

  // Immediate forms take the amount from shamt, variable forms from rs[4:0].
  // Unknown functs become a pass of rt flagged illegal; the amount is then
  // irrelevant and forced to zero.
  function automatic decode_t decode_funct(input logic [5:0] funct,
                                           input logic [4:0] shamt,
                                           input logic [4:0] rs_lo);
    decode_t d;
    d = '{op: OP_PASS, amt: 5'd0, illegal: 1'b1};
    case (funct)
      FUNCT_SLL:  d = '{op: OP_SLL, amt: shamt, illegal: 1'b0};
      FUNCT_SRL:  d = '{op: OP_SRL, amt: shamt, illegal: 1'b0};
      FUNCT_SRA:  d = '{op: OP_SRA, amt: shamt, illegal: 1'b0};
      FUNCT_SLLV: d = '{op: OP_SLL, amt: rs_lo, illegal: 1'b0};
      FUNCT_SRLV: d = '{op: OP_SRL, amt: rs_lo, illegal: 1'b0};
      FUNCT_SRAV: d = '{op: OP_SRA, amt: rs_lo, illegal: 1'b0};
      default:    d = '{op: OP_PASS, amt: 5'd0, illegal: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// -----------------------------------------------------------------------------
// Shifter
// Purely combinational barrel shifter used between the S1 and S2 registers.
// Ports:
//   op_i     - shift operation (SRL / SRA / SLL / PASS)
//   amt_i    - shift amount 0..31; 0 yields data_i for every operation
//   data_i   - operand (rt)
//   result_o - shifted result
// -----------------------------------------------------------------------------
module Shifter
  import shift_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  shift_op_e         op_i,
  input  logic [4:0]        amt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] result_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    result_o = data_i;
    case (op_i)
      OP_SRL:  result_o = data_i >> amt_i;
      OP_SRA:  result_o = $unsigned($signed(data_i) >>> amt_i);
      OP_SLL:  result_o = data_i << amt_i;
      OP_PASS: result_o = data_i;
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Two-stage shift execute pipeline with valid/ready handshakes on both sides.
//   S1: decoded bundle (shiftop, amount, rt, rd, illegal) registered on accept.
//   S2: registered shifter result, rd and illegal; presented downstream.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   - upstream handshake
//   in_funct, in_shamt    - instruction fields driving the decode
//   in_rs, in_rt, in_rd   - operands and destination tag
//   flush                 - drop every in-flight bundle at the next edge
//   out_valid / out_ready - downstream handshake
//   out_result, out_rd, out_illegal - result bundle, held while stalled
// -----------------------------------------------------------------------------
module shift_exec_stage
  import shift_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);

  // S1 state
  logic              s1_valid_q, s1_valid_d;
  shift_op_e         s1_op_q;
  logic [4:0]        s1_amt_q;
  logic [DATA_W-1:0] s1_rt_q;
  logic [4:0]        s1_rd_q;
  logic              s1_illegal_q;

  // S2 state
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_result_q;
  logic [4:0]        s2_rd_q;
  logic              s2_illegal_q;

  logic              s2_free;
  logic              s1_advance;
  logic              accept;
  decode_t           dec;
  logic [DATA_W-1:0] shift_result;

  // Only rs[4:0] feeds the variable-shift amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^in_rs[DATA_W-1:5];

  // Handshake: S2 empties or drains this cycle -> S1 may move into it, and
  // S1 then has room for a new bundle, so all three can happen together.
  assign s2_free    = !s2_valid_q || out_ready;
  assign s1_advance = s2_free;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;

  assign dec = decode_funct(in_funct, in_shamt, in_rs[4:0]);

  Shifter #(.DATA_W(DATA_W)) u_shifter (
    .op_i     (s1_op_q),
    .amt_i    (s1_amt_q),
    .data_i   (s1_rt_q),
    .result_o (shift_result)
  );

  // Valid bits: flush wins over movement; reset is applied in the register.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_free)  s2_valid_d = s1_valid_q;
      if (in_ready) s1_valid_d = in_valid;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // NOTE: the S1 payload has no reset; it is only observed through s1_valid_q,
  // so clearing it would add reset fanout for no behavioural gain. Flush never
  // touches payload registers either.
  always_ff @(posedge clock) begin
    if (!reset && !flush && accept) begin
      s1_op_q      <= dec.op;
      s1_amt_q     <= dec.amt;
      s1_rt_q      <= in_rt;
      s1_rd_q      <= in_rd;
      s1_illegal_q <= dec.illegal;
    end
  end

  // S2 payload is visible on the ports, so it is cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_result_q  <= '0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
    end else if (!flush && s1_valid_q && s2_free) begin
      s2_result_q  <= shift_result;
      s2_rd_q      <= s1_rd_q;
      s2_illegal_q <= s1_illegal_q;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_rd      = s2_rd_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream operand bundle valid.
REQ-005 SHALL have port in_ready, output, 1, stage can accept the bundle this cycle.
REQ-006 SHALL have port in_funct, input, 6, instruction funct field.
REQ-007 SHALL have port in_shamt, input, 5, instruction shamt field.
REQ-008 SHALL have ports in_rs and in_rt, input, 32 each, register operands.
REQ-009 SHALL have port in_rd, input, 5, destination register tag, carried unchanged.
REQ-010 SHALL have port flush, input, 1, discard all in-flight bundles.
REQ-011 SHALL have port out_valid, output, 1, result bundle valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have ports out_result (32), out_rd (5) and out_illegal (1), outputs, forming the result bundle.

Function
REQ-014 SHALL be a two-stage pipeline: S1 holds the decoded bundle, S2 holds the registered result.
REQ-015 SHALL accept the input bundle on a rising edge where in_valid && in_ready.
REQ-016 SHALL drive in_ready = !s1_valid || s1_advance, where s1_advance = s2_free and s2_free = !s2_valid || out_ready.
REQ-017 SHALL decode shiftop as: SLL/SLLV 000000/000100 -> 10; SRL/SRLV 000010/000110 -> 00; SRA/SRAV 000011/000111 -> 01.
REQ-018 SHALL take the shift amount from in_shamt for SLL/SRL/SRA and from in_rs[4:0] for SLLV/SRLV/SRAV; upper rs bits are ignored.
REQ-019 SHALL set shiftop 11 (pass-through of rt) for any other funct, and set illegal=1 for that bundle.
REQ-020 SHALL register shiftop, shift amount, rt, rd and illegal into S1 on accept; decode occurs before the S1 register.
REQ-021 SHALL compute the result combinationally from S1 through the shifter: 00 logical right, 01 arithmetic right (sign fill), 10 left with zero fill, 11 pass.
REQ-022 SHALL load S2 from S1 when s1_valid && s2_free; out_valid is the S2 valid bit.
REQ-023 SHALL give a latency of 2 cycles: a bundle accepted at edge N is presented on out_valid after edge N+1, absent backpressure.
REQ-024 SHALL hold out_result, out_rd and out_illegal stable while out_valid && !out_ready.
REQ-025 SHALL sustain a throughput of one bundle per cycle when out_ready is held high.
REQ-026 SHALL, at full with out_ready low, deassert in_ready and keep both stages unchanged.
REQ-027 SHALL, on a simultaneous S2 drain, S1 to S2 move and new accept in one cycle, perform all three with no loss or duplication.
REQ-028 SHALL preserve bundle order at output.
REQ-029 SHALL, on flush, clear s1_valid and s2_valid at the next edge; an input presented in that cycle is dropped and in_ready is don't-care.
REQ-030 SHALL not clear datapath registers on flush; only valid bits are cleared.
REQ-031 SHALL treat shift amount 0 as a pass of rt for every shift opcode.

Reset
REQ-032 SHALL, with reset high at an edge, clear s1_valid and s2_valid and drive out_result=0, out_rd=0 and out_illegal=0.
REQ-033 SHALL give reset priority over flush and accept, and SHALL drive in_ready=1 in the first cycle after reset.
REQ-034 SHALL discard in-flight bundles when reset is asserted mid-operation, with no output produced for them.

Structure
REQ-035 SHALL take funct codes and the shiftop encodings (00/01/10/11) from the shared package shift_defs.
REQ-036 SHALL instantiate the existing combinational sub-module Shifter once, between S1 and S2.
REQ-037 SHALL keep decode and handshake logic inside shift_exec_stage, with no further sub-modules.

Verification
REQ-038 SHALL cover: SRA, rt=0x80000000, shamt=4, out_ready=1 -> out_result=0xF8000000, out_illegal=0, 2 cycles after accept.
REQ-039 SHALL cover: SRLV, rs=0xFFFFFFE4, rt=0xF0000000 -> out_result=0x0F000000 (amount 4 from rs[4:0]).
REQ-040 SHALL cover: SLL, rt=0x12345678, shamt=0 -> 0x12345678; SLL with shamt=31 and rt=1 -> 0x80000000.
REQ-041 SHALL cover: funct=0x20, rt=0xDEADBEEF -> out_result=0xDEADBEEF, out_illegal=1.
REQ-042 SHALL cover: three back-to-back bundles with out_ready low for 3 cycles -> in_ready low after two accepts, results emitted in order once released, with no gaps.
REQ-043 SHALL cover: flush with both stages valid and in_valid=1 -> out_valid=0 next cycle and no output for any of the three bundles.
